ref_stream_unpack: RTL and testbench

- Width down-converter for the src_rdy/dst_rdy streaming handshake: accepts wide words of RATIO beats and emits them one narrow beat per transfer, low beat first.
- Sits on the read side of the DMA data path, between the wide buffer stage and narrow consumers, as the counterpart to the packing/buffering stages.
- Internal 2-entry wide buffer; both handshake outputs are registered, so no combinational path runs between the in and out handshakes.

---
 rtl/ref_stream_unpack.sv | 116 +++++++++++
 tb/tb_ref_stream_unpack.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_stream_unpack.sv
// Width down-converter: accepts wide words of RATIO beats on a src_rdy/dst_rdy
// stream and emits them low beat first, one narrow beat per transfer.
module ref_stream_unpack #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 4,
  parameter int CNT_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_src_rdy,
  output logic                       in_dst_rdy,
  input  logic [OUT_WIDTH*RATIO-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]       in_cnt,
  input  logic                       in_eop,
  output logic                       out_src_rdy,
  input  logic                       out_dst_rdy,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_eop
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;

  typedef struct packed {
    logic [IN_WIDTH-1:0]  data;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 eop;
  } slot_t;

  slot_t                slot_q [2];
  slot_t                slot_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           level_q, level_d;
  logic [CNT_WIDTH-1:0] beat_idx_q, beat_idx_d;
  logic                 in_dst_rdy_q, in_dst_rdy_d;
  logic                 out_src_rdy_q, out_src_rdy_d;

  logic in_en;
  logic out_en;
  logic last_beat;
  logic pop;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a missed path holds its old value and infers a latch.
    slot_d        = slot_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    beat_idx_d    = beat_idx_q;

    in_en     = in_src_rdy & in_dst_rdy_q;
    out_en    = out_src_rdy_q & out_dst_rdy;
    last_beat = (beat_idx_q == slot_q[rd_ptr_q].cnt);
    pop       = out_en & last_beat;

    // The write slot is always free while in_dst_rdy is high, so it may load
    // without waiting for in_src_rdy; only the pointer needs the handshake.
    if (in_dst_rdy_q) begin
      slot_d[wr_ptr_q] = '{data: in_data, cnt: in_cnt, eop: in_eop};
    end
    if (in_en) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      beat_idx_d = '0;
      rd_ptr_d   = ~rd_ptr_q;
    end else if (out_en) begin
      beat_idx_d = beat_idx_q + CNT_WIDTH'(1);
    end

    case ({in_en, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase

    // Handshake outputs are flops computed from the next level, so neither
    // side sees a combinational path from the other.
    in_dst_rdy_d  = (level_d <= 2'd1);
    out_src_rdy_d = (level_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two slots are reset along with the control state so the
      // narrow output reads zero while reset is held.
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      level_q       <= 2'd0;
      beat_idx_q    <= '0;
      in_dst_rdy_q  <= 1'b0;
      out_src_rdy_q <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // values from before this edge, independent of statement order.
      slot_q        <= slot_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      beat_idx_q    <= beat_idx_d;
      in_dst_rdy_q  <= in_dst_rdy_d;
      out_src_rdy_q <= out_src_rdy_d;
    end
  end

  assign in_dst_rdy  = in_dst_rdy_q;
  assign out_src_rdy = out_src_rdy_q;
  assign out_data    = slot_q[rd_ptr_q].data[beat_idx_q*OUT_WIDTH +: OUT_WIDTH];
  assign out_eop     = out_src_rdy_q & slot_q[rd_ptr_q].eop & last_beat;

endmodule

// File: tb/tb_ref_stream_unpack.sv
// Scoreboard bench for ref_stream_unpack: accepted words are expanded into
// expected beats, and a negedge monitor compares every emitted beat.
module tb_ref_stream_unpack;

  localparam int OW = 32;
  localparam int R  = 4;
  localparam int CW = 2;
  localparam int IW = OW * R;

  logic          clk;
  logic          rst_n;
  logic          in_src_rdy;
  logic          in_dst_rdy;
  logic [IW-1:0] in_data;
  logic [CW-1:0] in_cnt;
  logic          in_eop;
  logic          out_src_rdy;
  logic          out_dst_rdy;
  logic [OW-1:0] out_data;
  logic          out_eop;

  ref_stream_unpack #(.OUT_WIDTH(OW), .RATIO(R), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_src_rdy  (in_src_rdy),
    .in_dst_rdy  (in_dst_rdy),
    .in_data     (in_data),
    .in_cnt      (in_cnt),
    .in_eop      (in_eop),
    .out_src_rdy (out_src_rdy),
    .out_dst_rdy (out_dst_rdy),
    .out_data    (out_data),
    .out_eop     (out_eop)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          eop;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    lvl       = 0;   // words accepted but not yet fully emitted
  int    beats_out = 0;
  int    words_acc = 0;
  int    out_mode  = 0;   // percent chance out_dst_rdy is high each cycle
  int    cyc       = 0;
  bit    up;              // at least one clock edge since reset release

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) up <= rst_n;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    for (int k = 0; k < R; k++) w[k*OW +: OW] = $urandom;
    return w;
  endfunction

  // Downstream readiness, redrawn shortly after every rising edge.
  initial begin
    out_dst_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_dst_rdy = ($urandom_range(99) < out_mode);
    end
  end

  // Monitor: compare beats, track the word level, expand accepted words.
  beat_t mon_e;
  bit    mon_last;
  logic [IW-1:0] mon_w;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        lvl = 0;
      end else begin
        check("in_dst_rdy_vs_level", {63'd0, in_dst_rdy}, {63'd0, up && (lvl < 2)});
        check("out_src_rdy_vs_level", {63'd0, out_src_rdy}, {63'd0, lvl != 0});
        mon_last = 1'b0;
        if (out_src_rdy && out_dst_rdy) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            mon_e = sb.pop_front();
            check("out_data", {32'd0, out_data}, {32'd0, mon_e.data});
            check("out_eop", {63'd0, out_eop}, {63'd0, mon_e.eop});
            mon_last = mon_e.last;
          end
          beats_out++;
        end else if (!out_src_rdy) begin
          check("out_eop_idle", {63'd0, out_eop}, 64'd0);
        end
        if (in_src_rdy && in_dst_rdy) begin
          mon_w = in_data;
          for (int k = 0; k <= int'(in_cnt); k++) begin
            mon_e.data = mon_w[k*OW +: OW];
            mon_e.last = (k == int'(in_cnt));
            mon_e.eop  = in_eop && mon_e.last;
            sb.push_back(mon_e);
          end
          words_acc++;
          lvl++;
        end
        if (mon_last) lvl--;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [IW-1:0] d, input int cnt, input bit eop, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    in_data    = d;
    in_cnt     = CW'(cnt);
    in_eop     = eop;
    in_src_rdy = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_dst_rdy) break;
      if (t > 2000) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_src_rdy = 1'b0;
    in_data    = rand_word();
    in_cnt     = CW'($urandom_range(R - 1));
    in_eop     = 1'($urandom_range(1));
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 5000 && (sb.size() != 0 || lvl != 0); t++) @(posedge clk);
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, sent;
    logic [IW-1:0] w;
    logic [IW-1:0] known;
    int mix [4] = '{1, 3, 0, 2};

    rst_n = 1'b0; in_src_rdy = 1'b0; in_data = '0; in_cnt = '0; in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_dst_rdy", {63'd0, in_dst_rdy}, 64'd0);
    check("rst_out_src_rdy", {63'd0, out_src_rdy}, 64'd0);
    check("rst_out_eop", {63'd0, out_eop}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", {63'd0, in_dst_rdy}, 64'd0);
    @(posedge clk);
    #1;
    check("rdy_after_release", {63'd0, in_dst_rdy}, 64'd1);

    // Single full word, always-ready consumer.
    out_mode = 100;
    known = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    send_word(known, 3, 1'b1, 0);
    check("latency_valid", {63'd0, out_src_rdy}, 64'd1);
    check("latency_beat0", {32'd0, out_data}, 64'h11111111);
    wait_drain("drain_single");

    // Consumer stalled: two words buffered, third held until a slot frees.
    out_mode = 0;
    @(posedge clk);
    #1;
    base = words_acc;
    fork
      begin
        for (int i = 0; i < 3; i++) send_word(rand_word(), 3, 1'($urandom_range(1)), 0);
      end
      begin
        repeat (20) @(posedge clk);
        #2;
        check("held_accepted", 64'(words_acc - base), 64'd2);
        check("held_in_dst_rdy", {63'd0, in_dst_rdy}, 64'd0);
        out_mode = 100;
      end
    join
    wait_drain("drain_held");

    // Single-beat words stream at one word per cycle.
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_word(rand_word(), 0, 1'($urandom_range(1)), 0);
    check("cnt0_rate", 64'(cyc - c0), 64'd8);
    wait_drain("drain_cnt0");

    // Mixed lengths with a randomly stalling consumer.
    out_mode = 50;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) send_word(rand_word(), mix[i], 1'b1, $urandom_range(2));
    wait_drain("drain_mixed");

    // Reset in the middle of a word discards the buffered beats.
    out_mode = 100;
    base = beats_out;
    send_word(rand_word(), 3, 1'b1, 0);
    for (int t = 0; t < 100 && beats_out < base + 2; t++) @(posedge clk);
    if (beats_out < base + 2) fail_now("midword_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_src_rdy", {63'd0, out_src_rdy}, 64'd0);
    check("async_rst_in_dst_rdy", {63'd0, in_dst_rdy}, 64'd0);
    check("async_rst_out_data", {32'd0, out_data}, 64'd0);
    check("async_rst_out_eop", {63'd0, out_eop}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    w = rand_word();
    send_word(w, 2, 1'b1, 0);
    check("post_rst_beat0", {32'd0, out_data}, {32'd0, w[OW-1:0]});
    wait_drain("drain_post_rst");

    // Long random run with throttling on both sides.
    sent = 0;
    for (int i = 0; sent < 10000; i++) begin
      int cnt;
      if (i % 100 == 0) out_mode = $urandom_range(20, 100);
      cnt = $urandom_range(R - 1);
      send_word(rand_word(), cnt, 1'($urandom_range(1)),
                ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0);
      sent += cnt + 1;
    end
    out_mode = 100;
    wait_drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
